// File: rtl/dmem_arbiter_if.sv
// Bundle of the core load/store, external requester and data-memory signals
// around the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 32
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wdata;
  logic [2:0]    core_f3;
  logic          core_stall;
  logic [31:0]   core_rdata;
  logic          core_rvalid;

  logic          ext_valid;
  logic          ext_ready;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [31:0]   ext_wdata;
  logic [2:0]    ext_f3;
  logic [31:0]   ext_rdata;
  logic          ext_rvalid;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [2:0]    mem_f3;
  logic [31:0]   mem_rdata;

  // Arbiter side.
  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_f3,
    output core_stall, core_rdata, core_rvalid,
    input  ext_valid, ext_we, ext_addr, ext_wdata, ext_f3,
    output ext_ready, ext_rdata, ext_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_f3,
    input  mem_rdata
  );

  // Requesters plus memory model side.
  modport master (
    output core_req, core_we, core_addr, core_wdata, core_f3,
    input  core_stall, core_rdata, core_rvalid,
    output ext_valid, ext_we, ext_addr, ext_wdata, ext_f3,
    input  ext_ready, ext_rdata, ext_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_f3,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core and an
// external requester; reads are sequenced over LATENCY cycles.
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int LATENCY = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_CORE, WAIT_EXT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_last_ext;

  logic          w_idle;
  logic          w_grant_core;
  logic          w_grant_ext;
  logic          w_done;
  logic          w_core_rvalid;
  logic          w_ext_rvalid;
  logic [AW-1:0] w_addr;

  // No issue while reset is held, even though the state already reads IDLE.
  assign w_idle       = (r_state == IDLE) && i_rst_n;
  assign w_grant_core = w_idle && bus.core_req && (!bus.ext_valid || r_last_ext);
  assign w_grant_ext  = w_idle && bus.ext_valid && (!bus.core_req || !r_last_ext);

  assign w_done        = (r_cnt == 4'd0);
  assign w_core_rvalid = (r_state == WAIT_CORE) && w_done;
  assign w_ext_rvalid  = (r_state == WAIT_EXT) && w_done;

  always_comb begin
    w_addr = '0;
    if (w_grant_core)
      w_addr = bus.core_addr;
    else if (w_grant_ext)
      w_addr = bus.ext_addr;
  end

  assign bus.mem_en    = w_grant_core || w_grant_ext;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_we    = w_grant_core ? bus.core_we    : (w_grant_ext ? bus.ext_we    : 1'b0);
  assign bus.mem_wdata = w_grant_core ? bus.core_wdata : (w_grant_ext ? bus.ext_wdata : 32'd0);
  assign bus.mem_f3    = w_grant_core ? bus.core_f3    : (w_grant_ext ? bus.ext_f3    : 3'd0);

  // The core only proceeds on a granted store or on the cycle its load returns.
  assign bus.core_stall  = bus.core_req && !((w_grant_core && bus.core_we) || w_core_rvalid);
  assign bus.core_rvalid = w_core_rvalid;
  assign bus.core_rdata  = w_core_rvalid ? bus.mem_rdata : 32'd0;

  assign bus.ext_ready  = w_grant_ext;
  assign bus.ext_rvalid = w_ext_rvalid;
  assign bus.ext_rdata  = w_ext_rvalid ? bus.mem_rdata : 32'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_last_ext <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_core) begin
            r_last_ext <= 1'b0;
            if (!bus.core_we) begin
              r_state <= WAIT_CORE;
              r_cnt   <= CNT_INIT;
            end
          end else if (w_grant_ext) begin
            r_last_ext <= 1'b1;
            if (!bus.ext_we) begin
              r_state <= WAIT_EXT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT_CORE, WAIT_EXT: begin
          if (w_done)
            r_state <= IDLE;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: one arbiter at LATENCY=3 (sequencing, stalls, reset abort)
// and one at LATENCY=1 (round-robin contention).
module tb_dmem_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dmem_arbiter_if #(.AW(32)) bus_a ();
  dmem_arbiter_if #(.AW(32)) bus_b ();

  dmem_arbiter #(.AW(32), .LATENCY(3)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
  dmem_arbiter #(.AW(32), .LATENCY(1)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the low phase of the next cycle; inputs are driven here and
  // outputs sampled 1 ns later, well away from the rising edge.
  task automatic next_cycle(input string name);
    @(negedge clk);
    $display("step %s", name);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_a.core_req = 0; bus_a.core_we = 0; bus_a.core_addr = 0; bus_a.core_wdata = 0; bus_a.core_f3 = 0;
    bus_a.ext_valid = 0; bus_a.ext_we = 0; bus_a.ext_addr = 0; bus_a.ext_wdata = 0; bus_a.ext_f3 = 0;
    bus_a.mem_rdata = 32'hDEADBEEF;
    bus_b.core_req = 0; bus_b.core_we = 0; bus_b.core_addr = 0; bus_b.core_wdata = 0; bus_b.core_f3 = 0;
    bus_b.ext_valid = 0; bus_b.ext_we = 0; bus_b.ext_addr = 0; bus_b.ext_wdata = 0; bus_b.ext_f3 = 0;
    bus_b.mem_rdata = 32'h11112222;

    // Reset held with both sides requesting.
    next_cycle("reset_hold");
    bus_a.core_req = 1; bus_a.core_addr = 32'h100; bus_a.core_f3 = 3'd2;
    bus_a.ext_valid = 1; bus_a.ext_addr = 32'h200; bus_a.ext_f3 = 3'd2;
    #1;
    chk("rst_mem_en", 32'(bus_a.mem_en), 0);
    chk("rst_core_stall", 32'(bus_a.core_stall), 1);
    chk("rst_ext_ready", 32'(bus_a.ext_ready), 0);
    chk("rst_core_rvalid", 32'(bus_a.core_rvalid), 0);
    chk("rst_ext_rvalid", 32'(bus_a.ext_rvalid), 0);
    chk("rst_mem_addr", bus_a.mem_addr, 0);
    next_cycle("reset_hold2");
    #1;
    chk("rst2_mem_en", 32'(bus_a.mem_en), 0);

    // Release: core wins first conflict, load at 0x100, LATENCY=3 (cycle T).
    next_cycle("core_load_T");
    rst_n = 1'b1;
    #1;
    chk("T_mem_en", 32'(bus_a.mem_en), 1);
    chk("T_mem_addr", bus_a.mem_addr, 32'h100);
    chk("T_mem_we", 32'(bus_a.mem_we), 0);
    chk("T_ext_ready", 32'(bus_a.ext_ready), 0);
    chk("T_core_stall", 32'(bus_a.core_stall), 1);
    next_cycle("core_load_T1");
    #1;
    chk("T1_mem_en", 32'(bus_a.mem_en), 0);
    chk("T1_core_stall", 32'(bus_a.core_stall), 1);
    chk("T1_core_rvalid", 32'(bus_a.core_rvalid), 0);
    chk("T1_core_rdata", bus_a.core_rdata, 0);
    next_cycle("core_load_T2");
    #1;
    chk("T2_core_stall", 32'(bus_a.core_stall), 1);
    chk("T2_core_rvalid", 32'(bus_a.core_rvalid), 0);
    next_cycle("core_load_T3");
    #1;
    chk("T3_core_stall", 32'(bus_a.core_stall), 0);
    chk("T3_core_rvalid", 32'(bus_a.core_rvalid), 1);
    chk("T3_core_rdata", bus_a.core_rdata, 32'hDEADBEEF);
    chk("T3_mem_en", 32'(bus_a.mem_en), 0);

    // Pending ext read now issues; a core load then arrives during WAIT_EXT.
    next_cycle("ext_read_issue");
    bus_a.core_req = 0;
    #1;
    chk("E0_ext_ready", 32'(bus_a.ext_ready), 1);
    chk("E0_mem_addr", bus_a.mem_addr, 32'h200);
    chk("E0_mem_we", 32'(bus_a.mem_we), 0);
    next_cycle("core_req_in_wait_ext1");
    bus_a.ext_valid = 0;
    bus_a.core_req = 1; bus_a.core_addr = 32'h300;
    #1;
    chk("E1_core_stall", 32'(bus_a.core_stall), 1);
    chk("E1_mem_en", 32'(bus_a.mem_en), 0);
    chk("E1_ext_ready", 32'(bus_a.ext_ready), 0);
    next_cycle("core_req_in_wait_ext2");
    #1;
    chk("E2_core_stall", 32'(bus_a.core_stall), 1);
    next_cycle("ext_read_return");
    bus_a.mem_rdata = 32'hCAFEF00D;
    #1;
    chk("E3_ext_rvalid", 32'(bus_a.ext_rvalid), 1);
    chk("E3_ext_rdata", bus_a.ext_rdata, 32'hCAFEF00D);
    chk("E3_core_stall", 32'(bus_a.core_stall), 1);
    chk("E3_core_rvalid", 32'(bus_a.core_rvalid), 0);
    chk("E3_core_rdata", bus_a.core_rdata, 0);
    next_cycle("core_load_after_ext");
    #1;
    chk("E4_mem_en", 32'(bus_a.mem_en), 1);
    chk("E4_mem_addr", bus_a.mem_addr, 32'h300);
    chk("E4_core_stall", 32'(bus_a.core_stall), 1);
    chk("E4_ext_rvalid", 32'(bus_a.ext_rvalid), 0);

    // Reset at T+1 of the core read drops it; the load re-issues.
    next_cycle("reset_abort");
    rst_n = 1'b0;
    #1;
    chk("RA_core_rvalid", 32'(bus_a.core_rvalid), 0);
    chk("RA_mem_en", 32'(bus_a.mem_en), 0);
    next_cycle("reissue_T");
    rst_n = 1'b1;
    #1;
    chk("RI_mem_en", 32'(bus_a.mem_en), 1);
    chk("RI_mem_addr", bus_a.mem_addr, 32'h300);
    next_cycle("reissue_T1");
    #1;
    chk("RI1_core_rvalid", 32'(bus_a.core_rvalid), 0);
    chk("RI1_core_stall", 32'(bus_a.core_stall), 1);
    next_cycle("reissue_T2");
    #1;
    chk("RI2_core_rvalid", 32'(bus_a.core_rvalid), 0);
    next_cycle("reissue_T3");
    #1;
    chk("RI3_core_rvalid", 32'(bus_a.core_rvalid), 1);
    chk("RI3_core_rdata", bus_a.core_rdata, 32'hCAFEF00D);

    // Core store without contention.
    next_cycle("core_store");
    bus_a.core_we = 1; bus_a.core_addr = 32'h40; bus_a.core_wdata = 32'h12345678; bus_a.core_f3 = 3'd2;
    #1;
    chk("CS_mem_en", 32'(bus_a.mem_en), 1);
    chk("CS_mem_we", 32'(bus_a.mem_we), 1);
    chk("CS_mem_addr", bus_a.mem_addr, 32'h40);
    chk("CS_mem_wdata", bus_a.mem_wdata, 32'h12345678);
    chk("CS_mem_f3", 32'(bus_a.mem_f3), 2);
    chk("CS_core_stall", 32'(bus_a.core_stall), 0);
    next_cycle("idle");
    bus_a.core_req = 0; bus_a.core_we = 0;
    #1;
    chk("ID_mem_en", 32'(bus_a.mem_en), 0);
    chk("ID_mem_wdata", bus_a.mem_wdata, 0);
    chk("ID_core_stall", 32'(bus_a.core_stall), 0);

    // Back-to-back ext writes at full rate.
    next_cycle("ext_write1");
    bus_a.ext_valid = 1; bus_a.ext_we = 1; bus_a.ext_addr = 32'h80; bus_a.ext_wdata = 32'hA5A5A5A5; bus_a.ext_f3 = 3'd1;
    #1;
    chk("EW1_ext_ready", 32'(bus_a.ext_ready), 1);
    chk("EW1_mem_we", 32'(bus_a.mem_we), 1);
    chk("EW1_mem_wdata", bus_a.mem_wdata, 32'hA5A5A5A5);
    chk("EW1_mem_f3", 32'(bus_a.mem_f3), 1);
    next_cycle("ext_write2");
    bus_a.ext_addr = 32'h84; bus_a.ext_wdata = 32'h5A5A5A5A;
    #1;
    chk("EW2_ext_ready", 32'(bus_a.ext_ready), 1);
    chk("EW2_mem_addr", bus_a.mem_addr, 32'h84);
    next_cycle("ext_idle");
    bus_a.ext_valid = 0; bus_a.ext_we = 0;
    #1;
    chk("EW3_ext_ready", 32'(bus_a.ext_ready), 0);

    // Continuous contention on the LATENCY=1 instance.
    next_cycle("cont_T");
    bus_b.core_req = 1; bus_b.core_addr = 32'h10;
    bus_b.ext_valid = 1; bus_b.ext_addr = 32'h20;
    #1;
    chk("C0_mem_addr", bus_b.mem_addr, 32'h10);
    chk("C0_ext_ready", 32'(bus_b.ext_ready), 0);
    chk("C0_core_stall", 32'(bus_b.core_stall), 1);
    next_cycle("cont_T1");
    #1;
    chk("C1_core_rvalid", 32'(bus_b.core_rvalid), 1);
    chk("C1_core_rdata", bus_b.core_rdata, 32'h11112222);
    chk("C1_core_stall", 32'(bus_b.core_stall), 0);
    chk("C1_ext_ready", 32'(bus_b.ext_ready), 0);
    next_cycle("cont_T2");
    #1;
    chk("C2_ext_ready", 32'(bus_b.ext_ready), 1);
    chk("C2_mem_addr", bus_b.mem_addr, 32'h20);
    chk("C2_core_stall", 32'(bus_b.core_stall), 1);
    next_cycle("cont_T3");
    #1;
    chk("C3_ext_rvalid", 32'(bus_b.ext_rvalid), 1);
    chk("C3_ext_rdata", bus_b.ext_rdata, 32'h11112222);
    chk("C3_ext_ready", 32'(bus_b.ext_ready), 0);
    chk("C3_core_stall", 32'(bus_b.core_stall), 1);
    next_cycle("cont_T4");
    #1;
    chk("C4_mem_addr", bus_b.mem_addr, 32'h10);
    chk("C4_ext_ready", 32'(bus_b.ext_ready), 0);
    chk("C4_core_stall", 32'(bus_b.core_stall), 1);
    next_cycle("cont_T5");
    #1;
    chk("C5_core_rvalid", 32'(bus_b.core_rvalid), 1);
    next_cycle("cont_T6");
    #1;
    chk("C6_ext_ready", 32'(bus_b.ext_ready), 1);
    chk("C6_mem_addr", bus_b.mem_addr, 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the core load/store path and an external requester (debug/DMA loader).
- Sequences each access over a configurable memory read latency and stalls the core while its load is in flight.
- Sits between the core's ALU-address/rd2/funct3/memWrite signals and the data memory.
- Arbitration is round-robin on contention.

Parameters:
- AW, 32, address width of all address ports.
- LATENCY, 1, cycles from issue to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core has a load/store this cycle.
- core_we  in  1  core access is a store.
- core_addr  in  AW  core byte address.
- core_wdata  in  32  core store data.
- core_f3  in  3  core funct3 (size/sign).
- core_stall  out  1  hold PC and pipeline state.
- core_rdata  out  32  load data to the load extender.
- core_rvalid  out  1  core_rdata valid this cycle.
- ext_valid  in  1  external request pending.
- ext_ready  out  1  external request accepted this cycle.
- ext_we  in  1  external access is a write.
- ext_addr  in  AW  external byte address.
- ext_wdata  in  32  external write data.
- ext_f3  in  3  external funct3.
- ext_rdata  out  32  external read data.
- ext_rvalid  out  1  ext_rdata valid this cycle.
- mem_en  out  1  issue strobe to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  AW  memory address.
- mem_wdata  out  32  memory write data.
- mem_f3  out  3  memory funct3.
- mem_rdata  in  32  memory read data, valid LATENCY cycles after a read issue.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, wait counter=0, last_grant=EXT, so the core wins the first conflict.
  - All registered outputs are 0; core_stall=0 with core_req=0.
  - An in-flight read is dropped; no rvalid is ever produced for it.
- States: IDLE, WAIT_CORE, WAIT_EXT.
- IDLE, issue cycle T:
  - Candidates are core_req and ext_valid.
  - If only one is present, grant it.
  - If both are present, grant the side that is not last_grant, then update last_grant.
  - Granted side drives mem_en=1 and mem_we/addr/wdata/f3 combinationally from that side's inputs for exactly cycle T.
  - With no grant, mem_en=0 and the mem_* data outputs are 0.
- Writes: complete in cycle T and state stays IDLE.
  - Core write: core_stall=0 in T.
  - Ext write: ext_ready=1 in T.
- Reads: state moves to WAIT_CORE or WAIT_EXT with counter=LATENCY-1. If LATENCY=1, the WAIT state lasts one cycle.
- Read data return (T+LATENCY):
  - The counter decrements each WAIT cycle.
  - On the cycle where the counter reaches 0 (cycle T+LATENCY), rvalid for the owner =1 and rdata=mem_rdata (combinational pass-through).
  - State returns to IDLE next cycle.
- core_stall:
  - =1 whenever core_req=1 and the core access is not completing this cycle.
  - Core read: stall=1 from T to T+LATENCY-1, and 0 at T+LATENCY.
  - Core loses arbitration: stall=1 with core_req=1.
  - Core request present while WAIT_EXT: stall=1.
- ext_ready:
  - =1 only in the issue cycle of an ext access.
  - The external side must hold valid, we, addr, wdata and f3 stable until ready.
  - A read completes later via ext_rvalid.
  - ext_valid may not be deasserted before ready; this is a protocol error and the behaviour is undefined.
- No issue occurs in WAIT states, so there is at most one access in flight.
- Turnaround:
  - The next issue is possible at T+LATENCY+1 for reads and T+1 for writes.
  - Back-to-back writes run at full rate.
- core_rdata and ext_rdata are 0 when the corresponding rvalid=0.
- Fairness: under continuous contention, grants alternate CORE, EXT, CORE, ...; neither side waits more than one access of the other.

Test Plan:
- Reset: hold reset=0 with both requests high -> mem_en=0, core_stall=1, ext_ready=0, all rvalid=0. Release -> core is granted first at the first rising edge.
- Core load, LATENCY=3: core_req=1, we=0, addr=0x100, mem returns 0xDEADBEEF at T+3:
  - mem_en=1 only at T.
  - core_stall=1 at T..T+2.
  - At T+3: core_stall=0, core_rvalid=1, core_rdata=0xDEADBEEF.
- Core store with no contention: addr=0x40, wdata=0x12345678, f3=2 -> mem_en=mem_we=1 with those values in one cycle, core_stall=0 throughout.
- Contention, LATENCY=1, both sides reading continuously:
  - Grants go CORE at T, EXT at T+2, CORE at T+4.
  - ext_ready pulses at T+2 only.
  - core_stall=1 at T+2..T+3.
- Ext write while core is idle, then core load arrives during WAIT_EXT after an ext read -> core stalls until the ext read completes, then the core load issues in the following IDLE cycle.
- Reset asserted at T+1 of a LATENCY=3 core read -> state IDLE immediately; after release, no core_rvalid pulse appears and the core load re-issues.
